retire_trace_packer: RTL and testbench
======================================

Name: retire_trace_packer

Overview:
- Downstream consumer of the single-cycle core's retirement outputs: pc, instruction, reg_write, rd_address, write_data.
- Captures one record per retired instruction into a small FIFO.
- Serialises each record into a byte packet on a valid/ready stream, for a UART or debug-port bridge.
- Decouples the core's one-instruction-per-cycle rate from a slow trace sink; counts records dropped on overflow.

Parameters:
- DEPTH, 8, FIFO record entries; power of two, ≥2.
- ADDR_W, 3, log2(DEPTH).
- HEADER, 8'hA5, packet sync byte when no drop preceded the packet; HEADER+1 when a drop preceded it.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- retire_valid  in  1  one instruction retires this cycle.
- retire_pc  in  32  PC of the retired instruction.
- retire_instr  in  32  instruction word.
- retire_reg_write  in  1  register-file write performed.
- retire_rd  in  5  destination register address.
- retire_data  in  32  value written to rd.
- m_valid  out  1  m_data holds a valid byte.
- m_ready  in  1  sink accepts a byte.
- m_data  out  8  packet byte.
- m_last  out  1  current byte is the final byte of the packet.
- fifo_level  out  ADDR_W+1  records currently held in the FIFO; the packet being sent is excluded.
- overflow_count  out  16  records dropped since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (reset==0 at an edge): FIFO pointers and fifo_level = 0; m_valid = 0; m_data = 0; m_last = 0; overflow_count = 0; drop_pending = 0; FSM = IDLE.
  - Reset mid-packet discards the in-flight packet and all queued records.
- Push: at an edge with retire_valid=1:
  - Record {pc, instr, data, rd, reg_write} is written if the FIFO is not full, or if a pop occurs at the same edge.
  - Otherwise the record is dropped: overflow_count increments (saturating) and drop_pending is set.
- Records are stored unmodified; rd=0 with reg_write=1 is reported as-is.
- Packet format, 14 bytes, sent in this order:
  - byte0: header — HEADER, or HEADER+1 if drop_pending was set when the packet was loaded.
  - byte1: {reg_write, 2'b00, rd[4:0]}.
  - bytes2-5: pc, MSB first.
  - bytes6-9: instr, MSB first.
  - bytes10-13: data, MSB first.
- Loading a packet clears drop_pending.
  - If a drop occurs at the same edge as a load, drop_pending remains set and applies to the next packet.
- FSM has two states, IDLE and SEND.
  - IDLE: if the FIFO is non-empty at an edge, pop the head into the packet register, byte index = 0, m_valid = 1, next state SEND.
  - SEND: a byte transfers at an edge where m_valid && m_ready.
    - Non-final byte: index increments.
    - Final byte with FIFO non-empty: load the next record at the same edge, so there is no bubble cycle.
    - Final byte with FIFO empty: m_valid = 0, next state IDLE.
- Stream stability: while m_valid && !m_ready, m_data and m_last hold stable. m_valid never drops without a handshake, except on reset.
- m_last = 1 only on the final byte (index 13).
- Latency: record pushed at edge N → FIFO non-empty after N → m_valid = 1 with byte0 after edge N+1 if the FSM was IDLE.
- fifo_level:
  - push only: +1.
  - pop only: −1.
  - push and pop at the same edge: unchanged.
  - Never exceeds DEPTH.

Optional Feature:
- Macro: TRACE_COMPRESS_EN.
- Defined: records with reg_write = 0 produce a 10-byte packet (bytes 0-9); m_last asserts on byte 9. Records with reg_write = 1 keep the 14-byte packet.
- Undefined: every packet is 14 bytes, and bytes10-13 carry retire_data whatever the value of reg_write.

Test Plan:
1. Single record, m_ready held 1: pc=0x00000004, instr=0x00500093, reg_write=1, rd=1, data=0x00000005.
   → m_valid rises one edge after the push.
   → bytes: A5, 81, 00 00 00 04, 00 50 00 93, 00 00 00 05.
   → m_last on byte 14 only; m_valid drops the next cycle.
2. Backpressure: m_ready=0 for 5 cycles after byte0.
   → m_data stays 0xA5 and m_valid stays 1 throughout; the stream resumes intact.
3. Overflow: m_ready=0; push 11 consecutive records with DEPTH=8.
   → fifo_level = 8; overflow_count = 2. Entry 1 is loaded into the packet register, so it does not count toward fifo_level.
   → release m_ready: packet 1 header A5, packet 2 header A6, remaining packets A5.
4. Back-to-back: 3 records pushed, m_ready=1.
   → 42 consecutive handshake cycles with no m_valid gap; m_last pulses 3 times.
5. Reset mid-packet: assert reset=0 after byte 6 of a packet.
   → next cycle m_valid=0, fifo_level=0, overflow_count=0; no residual bytes after release.
6. TRACE_COMPRESS_EN defined: record with reg_write=0, rd=0.
   → 10-byte packet starting A5, 00; m_last on byte 10.

Source files
------------

// File: rtl/retire_trace_packer_if.sv
// retire_trace_packer_if: retirement capture inputs plus the outgoing byte stream.
// The master modport is the packer's view; slave is the core/sink side.
interface retire_trace_packer_if;
    logic        retire_valid;
    logic [31:0] retire_pc;
    logic [31:0] retire_instr;
    logic        retire_reg_write;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    modport master (
        input  retire_valid, retire_pc, retire_instr, retire_reg_write, retire_rd, retire_data, m_ready,
        output m_valid, m_data, m_last
    );
    modport slave (
        output retire_valid, retire_pc, retire_instr, retire_reg_write, retire_rd, retire_data, m_ready,
        input  m_valid, m_data, m_last
    );
endinterface

// File: rtl/retire_trace_packer.sv
// retire_trace_packer: FIFOs retired instructions and serialises each into a byte packet.
// TRACE_COMPRESS_EN shortens packets of non-writing instructions to 10 bytes.
module retire_trace_packer #(
    parameter int         DEPTH  = 8,
    parameter int         ADDR_W = 3,
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    retire_trace_packer_if.master bus,
    output logic [ADDR_W:0]       fifo_level,
    output logic [15:0]           overflow_count
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_write;
    } rec_t;
    typedef enum logic {IDLE, SEND} state_t;

    state_t            state, state_n;
    rec_t              mem [DEPTH];
    rec_t              pkt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [3:0]        idx, last_idx;
    logic              drop_pending, pkt_drop, empty, full, hs, done, pop, push, drop;
    logic [7:0]        bytes [16];

    assign empty       = fifo_level == '0;
    assign full        = fifo_level == (ADDR_W+1)'(DEPTH);
    assign bus.m_valid = state == SEND;
    assign hs          = bus.m_valid && bus.m_ready;
    assign push        = bus.retire_valid && (!full || pop);
    assign drop        = bus.retire_valid && !push;
`ifdef TRACE_COMPRESS_EN
    assign last_idx = pkt.reg_write ? 4'd13 : 4'd9;
`else
    assign last_idx = 4'd13;
`endif

    // Finishing a packet and sitting idle both hand the FIFO head straight to the packet register.
    always_comb begin
        done    = state == IDLE || (hs && idx == last_idx);
        pop     = done && !empty;
        state_n = done ? (empty ? IDLE : SEND) : state;
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        bytes    = '{default: 8'h00};
        bytes[0] = HEADER + {7'd0, pkt_drop};
        bytes[1] = {pkt.reg_write, 2'b00, pkt.rd};
        {bytes[2], bytes[3], bytes[4], bytes[5]}     = pkt.pc;
        {bytes[6], bytes[7], bytes[8], bytes[9]}     = pkt.instr;
        {bytes[10], bytes[11], bytes[12], bytes[13]} = pkt.data;
    end

    assign bus.m_data = bus.m_valid ? bytes[idx] : 8'h00;
    assign bus.m_last = bus.m_valid && idx == last_idx;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{bus.retire_pc, bus.retire_instr, bus.retire_data, bus.retire_rd, bus.retire_reg_write};
        if (pop)  pkt <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            overflow_count <= '0;
            drop_pending   <= 1'b0;
            pkt_drop       <= 1'b0;
            idx            <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                idx      <= '0;
                pkt_drop <= drop_pending;
            end else if (hs) begin
                idx <= idx + 4'd1;
            end
            fifo_level   <= fifo_level + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
            // A drop coinciding with a load is charged to the following packet.
            drop_pending <= pop ? drop : (drop_pending | drop);
            if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_retire_trace_packer.sv
// tb_retire_trace_packer: table-driven packets plus backpressure, overflow, back-to-back and reset sequences.
module tb_retire_trace_packer;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_level;
    logic [15:0] overflow_count;

    always #5 clk = ~clk;

    retire_trace_packer_if bus();
    retire_trace_packer dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .fifo_level(fifo_level),
        .overflow_count(overflow_count)
    );

`ifdef TRACE_COMPRESS_EN
    localparam int SHORT = 10;
`else
    localparam int SHORT = 14;
`endif

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [7:0]  b1;
        int          len;
    } vec_t;

    exp_t q[$];
    int total = 0, bad = 0, cyc = 0, hs_cnt = 0, last_cnt = 0, first_v = -1, last_v = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Byte compare happens on the falling edge, before the rising edge that transfers it.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.m_valid) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (bus.m_valid && bus.m_ready) begin
            hs_cnt++;
            if (bus.m_last) last_cnt++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got %02h want none", bus.m_data);
            end else begin
                e = q.pop_front();
                check("m_data", {24'd0, bus.m_data}, {24'd0, e.d});
                check("m_last", {31'd0, bus.m_last}, {31'd0, e.l});
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic rw,
                                input logic [4:0] rd, input logic [31:0] data);
        vec_t v;
        v.pc = pc; v.instr = instr; v.rw = rw; v.rd = rd; v.data = data;
        v.b1 = {rw, 2'b00, rd};
        v.len = rw ? 14 : SHORT;
        return v;
    endfunction

    task automatic push_exp(input vec_t v, input logic [7:0] hdr);
        logic [7:0] b [14];
        b[0] = hdr;
        b[1] = v.b1;
        {b[2], b[3], b[4], b[5]}     = v.pc;
        {b[6], b[7], b[8], b[9]}     = v.instr;
        {b[10], b[11], b[12], b[13]} = v.data;
        for (int i = 0; i < v.len; i++) q.push_back('{d: b[i], l: (i == v.len - 1)});
    endtask

    task automatic drive(input vec_t v);
        bus.retire_valid     = 1'b1;
        bus.retire_pc        = v.pc;
        bus.retire_instr     = v.instr;
        bus.retire_reg_write = v.rw;
        bus.retire_rd        = v.rd;
        bus.retire_data      = v.data;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", q.size(), 0);
    endtask

    vec_t tbl [5];
    vec_t v;
    int   h0, l0, n;

    initial begin
        tbl[0] = '{32'h0000_0004, 32'h0050_0093, 1'b1, 5'd1,  32'h0000_0005, 8'h81, 14};
        tbl[1] = '{32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 5'd0,  32'h1234_5678, 8'h00, SHORT};
        tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0013, 1'b1, 5'd0,  32'hCAFE_F00D, 8'h80, 14};
        tbl[3] = '{32'h0000_1000, 32'h00A0_0193, 1'b1, 5'd31, 32'h0000_000A, 8'h9F, 14};
        tbl[4] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5'd5,  32'h0000_0000, 8'h05, SHORT};

        reset = 1'b0;
        bus.m_ready = 1'b0;
        bus.retire_valid = 1'b0;
        bus.retire_pc = '0; bus.retire_instr = '0; bus.retire_reg_write = 1'b0;
        bus.retire_rd = '0; bus.retire_data = '0;
        repeat (3) tick();
        check("rst_m_valid", {31'd0, bus.m_valid}, 0);
        check("rst_m_data", {24'd0, bus.m_data}, 0);
        check("rst_m_last", {31'd0, bus.m_last}, 0);
        check("rst_level", {28'd0, fifo_level}, 0);
        check("rst_ovf", {16'd0, overflow_count}, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            bus.m_ready = 1'b1;
            drive(tbl[i]);
            push_exp(tbl[i], 8'hA5);
            tick();
            bus.retire_valid = 1'b0;
            check("lat_valid_low", {31'd0, bus.m_valid}, 0);
            check("lat_level1", {28'd0, fifo_level}, 1);
            tick();
            check("lat_valid_high", {31'd0, bus.m_valid}, 1);
            check("lat_header", {24'd0, bus.m_data}, 32'hA5);
            check("lat_level0", {28'd0, fifo_level}, 0);
            drain(40);
            check("valid_drop", {31'd0, bus.m_valid}, 0);
        end

        bus.m_ready = 1'b0;
        v = mk(32'h100, 32'h0000_0013, 1'b1, 5'd2, 32'h77);
        drive(v);
        push_exp(v, 8'hA5);
        tick();
        bus.retire_valid = 1'b0;
        tick();
        repeat (5) begin
            tick();
            check("bp_valid", {31'd0, bus.m_valid}, 1);
            check("bp_data", {24'd0, bus.m_data}, 32'hA5);
        end
        bus.m_ready = 1'b1;
        drain(40);

        bus.m_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            v = mk(32'h2000 + 32'(4 * i), 32'h0010_0093 + 32'(i), 1'b1, 5'(i + 1), 32'h1000 + 32'(i));
            drive(v);
            if (i < 9) push_exp(v, i == 1 ? 8'hA6 : 8'hA5);
            tick();
        end
        bus.retire_valid = 1'b0;
        check("ovf_level", {28'd0, fifo_level}, 8);
        check("ovf_count", {16'd0, overflow_count}, 2);
        bus.m_ready = 1'b1;
        drain(9 * 14 + 20);
        check("ovf_level_empty", {28'd0, fifo_level}, 0);

        first_v = -1; last_v = -1; h0 = hs_cnt; l0 = last_cnt;
        for (int i = 0; i < 3; i++) begin
            v = mk(32'h3000 + 32'(4 * i), 32'h0020_0113 + 32'(i), 1'b1, 5'(i + 3), 32'hA0 + 32'(i));
            drive(v);
            push_exp(v, 8'hA5);
            tick();
        end
        bus.retire_valid = 1'b0;
        drain(60);
        check("b2b_span", last_v - first_v + 1, 42);
        check("b2b_hs", hs_cnt - h0, 42);
        check("b2b_last", last_cnt - l0, 3);

        h0 = hs_cnt;
        for (int i = 0; i < 2; i++) begin
            v = mk(32'h4000 + 32'(4 * i), 32'h0030_0193, 1'b1, 5'd7, 32'h55 + 32'(i));
            drive(v);
            push_exp(v, 8'hA5);
            tick();
        end
        bus.retire_valid = 1'b0;
        n = 0;
        while (hs_cnt - h0 < 6 && n < 20) begin
            tick();
            n++;
        end
        check("mid_bytes_sent", hs_cnt - h0, 6);
        check("mid_level", {28'd0, fifo_level}, 1);
        check("mid_ovf", {16'd0, overflow_count}, 2);
        bus.m_ready = 1'b0;
        reset = 1'b0;
        q.delete();
        tick();
        check("mrst_valid", {31'd0, bus.m_valid}, 0);
        check("mrst_level", {28'd0, fifo_level}, 0);
        check("mrst_ovf", {16'd0, overflow_count}, 0);
        check("mrst_data", {24'd0, bus.m_data}, 0);
        check("mrst_last", {31'd0, bus.m_last}, 0);
        reset = 1'b1;
        bus.m_ready = 1'b1;
        h0 = hs_cnt;
        repeat (20) tick();
        check("mrst_residual", hs_cnt - h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
